// File: rtl/axi4_lite_sram.sv
// axi4_lite_sram: AXI4-Lite word-array slave with independent read/write FSMs and response latency.
// Define RAND_DELAY_EN to draw each response delay from an 8-bit LFSR instead of LATENCY.
module axi4_lite_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) * 32'd4;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    logic [31:0] mem [DEPTH];
    state_e      rstate_q, rstate_d, wstate_q, wstate_d;
    logic [3:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d, dly;
    logic [31:0] rdata_q, roff, woff;
    logic [1:0]  rresp_q, bresp_q;
    logic        r_hit, w_hit, ar_hs, aw_hs;
    logic [IW-1:0] r_idx, w_idx;

`ifdef RAND_DELAY_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign dly = lfsr_q[3:0];
`else
    assign dly = 4'(LATENCY);
`endif

    assign roff  = araddr_i - BASE_ADDR;
    assign woff  = awaddr_i - BASE_ADDR;
    assign r_hit = (araddr_i >= BASE_ADDR) && (roff < SPAN);
    assign w_hit = (awaddr_i >= BASE_ADDR) && (woff < SPAN);
    assign r_idx = roff[IW+1:2];
    assign w_idx = woff[IW+1:2];
    assign ar_hs = arvalid_i & arready_o;
    assign aw_hs = awready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= S_IDLE;
            wstate_q <= S_IDLE;
            rcnt_q   <= 4'd0;
            wcnt_q   <= 4'd0;
        end else begin
            rstate_q <= rstate_d;
            wstate_q <= wstate_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // The count holds delay-1 so the response lands exactly delay cycles after WAIT entry.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        case (rstate_q)
            S_IDLE: if (ar_hs) begin
                rstate_d = (dly == 4'd0) ? S_RESP : S_WAIT;
                rcnt_d   = (dly == 4'd0) ? 4'd0 : dly - 4'd1;
            end
            S_WAIT: begin
                rstate_d = (rcnt_q == 4'd0) ? S_RESP : S_WAIT;
                rcnt_d   = (rcnt_q == 4'd0) ? 4'd0 : rcnt_q - 4'd1;
            end
            S_RESP:  rstate_d = rready_i ? S_IDLE : S_RESP;
            default: rstate_d = S_IDLE;
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        case (wstate_q)
            S_IDLE: if (aw_hs) begin
                wstate_d = (dly == 4'd0) ? S_RESP : S_WAIT;
                wcnt_d   = (dly == 4'd0) ? 4'd0 : dly - 4'd1;
            end
            S_WAIT: begin
                wstate_d = (wcnt_q == 4'd0) ? S_RESP : S_WAIT;
                wcnt_d   = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
            end
            S_RESP:  wstate_d = bready_i ? S_IDLE : S_RESP;
            default: wstate_d = S_IDLE;
        endcase
    end

    always_comb begin
        arready_o = !rst && rstate_q == S_IDLE;
        rvalid_o  = !rst && rstate_q == S_RESP;
        awready_o = !rst && wstate_q == S_IDLE && awvalid_i && wvalid_i;
        wready_o  = awready_o;
        bvalid_o  = !rst && wstate_q == S_RESP;
    end

    // Read data is captured on the AR edge, so a same-edge write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
            rresp_q <= OKAY;
            bresp_q <= OKAY;
        end else begin
            if (ar_hs) begin
                rdata_q <= r_hit ? mem[r_idx] : 32'd0;
                rresp_q <= r_hit ? OKAY : SLVERR;
            end
            if (aw_hs) bresp_q <= w_hit ? OKAY : SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs && w_hit)
            for (int k = 0; k < 4; k++)
                if (wstrb_i[k]) mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end

    assign rdata_o = rdata_q;
    assign rresp_o = rresp_q;
    assign bresp_o = bresp_q;
endmodule
